// File: rtl/dds_pkg.sv
// Shared types and default widths for the DDS sweep sequencer.
package dds_pkg;

    localparam int unsigned DDS_PHASE_W = 32;
    localparam int unsigned DDS_ADDR_W  = 14;
    localparam int unsigned DDS_CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } state_t;

    typedef struct packed {
        logic [DDS_PHASE_W-1:0] f_start;
        logic [DDS_PHASE_W-1:0] f_step;
        logic [DDS_CNT_W-1:0]   steps;
        logic [DDS_CNT_W-1:0]   dwell;
    } cfg_t;

endpackage

// File: rtl/dds_sweep_ctrl_phase_acc.sv
// Phase accumulator with clear/enable and a registered ROM address taken
// from the top ADDR_W bits of the accumulator (one cycle behind it).
module dds_phase_acc #(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned ADDR_W  = 14
) (
    input  logic               clk_125m,
    input  logic               sys_rst_n,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [PHASE_W-1:0] fword_i,
    output logic [ADDR_W-1:0]  addr_o
);

    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [ADDR_W-1:0]  addr_q;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + fword_i;
        end
    end

    always_ff @(posedge clk_125m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            acc_q  <= '0;
            addr_q <= '0;
        end else begin
            acc_q  <= acc_d;
            addr_q <= acc_q[PHASE_W-1 -: ADDR_W];
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer owning the DDS phase accumulator.
// Define DDS_SWEEP_BIDIR_EN to sweep back down to f_start after the top step.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int unsigned PHASE_W = DDS_PHASE_W,
    parameter int unsigned ADDR_W  = DDS_ADDR_W,
    parameter int unsigned CNT_W   = DDS_CNT_W
) (
    input  logic               clk_125m,
    input  logic               sys_rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_f_start,
    input  logic [PHASE_W-1:0] cfg_f_step,
    input  logic [CNT_W-1:0]   cfg_steps,
    input  logic [CNT_W-1:0]   cfg_dwell,
    input  logic               start,
    input  logic               pause,
    input  logic               abort,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic [PHASE_W-1:0] cur_fword,
    output logic               busy,
    output logic               done
);

    state_t             state_q, state_d;
    cfg_t               cfg_q, cfg_d;
    logic [PHASE_W-1:0] fword_q, fword_d;
    logic [CNT_W-1:0]   step_q, step_d;
    logic [CNT_W-1:0]   dwell_q, dwell_d;
    logic               done_q, done_d;
    logic               acc_clr, acc_en;
    logic [CNT_W-1:0]   dwell_max;
    logic               dwell_end;
`ifdef DDS_SWEEP_BIDIR_EN
    logic               dir_q, dir_d;
`endif

    assign dwell_max = (cfg_q.dwell == '0) ? CNT_W'(1) : cfg_q.dwell;
    assign dwell_end = (dwell_q == dwell_max - 1'b1);

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        fword_d = fword_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        done_d  = 1'b0;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
        dir_d   = dir_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    cfg_d = '{f_start: cfg_f_start, f_step: cfg_f_step,
                              steps: cfg_steps, dwell: cfg_dwell};
                end
                if (start) begin
                    state_d = RUN;
                    fword_d = cfg_valid ? cfg_f_start : cfg_q.f_start;
                    step_d  = '0;
                    dwell_d = '0;
                    acc_clr = 1'b1;
`ifdef DDS_SWEEP_BIDIR_EN
                    dir_d   = 1'b0;
`endif
                end
            end
            RUN: begin
                // abort/pause freeze the cycle they are sampled in
                if (abort) begin
                    state_d = IDLE;
                end else if (pause) begin
                    state_d = PAUSE;
                end else begin
                    acc_en = 1'b1;
                    if (!dwell_end) begin
                        dwell_d = dwell_q + 1'b1;
                    end else begin
                        dwell_d = '0;
`ifdef DDS_SWEEP_BIDIR_EN
                        if (!dir_q && step_q != cfg_q.steps) begin
                            fword_d = fword_q + cfg_q.f_step;
                            step_d  = step_q + 1'b1;
                        end else if (!dir_q && step_q != '0) begin
                            dir_d   = 1'b1;
                            fword_d = fword_q - cfg_q.f_step;
                            step_d  = step_q - 1'b1;
                        end else if (dir_q && step_q != '0) begin
                            fword_d = fword_q - cfg_q.f_step;
                            step_d  = step_q - 1'b1;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
`else
                        if (step_q == cfg_q.steps) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            fword_d = fword_q + cfg_q.f_step;
                            step_d  = step_q + 1'b1;
                        end
`endif
                    end
                end
            end
            PAUSE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!pause) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_125m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            fword_q <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            done_q  <= 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            fword_q <= fword_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            done_q  <= done_d;
`ifdef DDS_SWEEP_BIDIR_EN
            dir_q   <= dir_d;
`endif
        end
    end

    dds_phase_acc #(
        .PHASE_W (PHASE_W),
        .ADDR_W  (ADDR_W)
    ) u_phase_acc (
        .clk_125m  (clk_125m),
        .sys_rst_n (sys_rst_n),
        .clr_i     (acc_clr),
        .en_i      (acc_en),
        .fword_i   (fword_q),
        .addr_o    (rom_addr)
    );

    assign cur_fword = fword_q;
    assign busy      = (state_q != IDLE);
    assign cfg_ready = (state_q == IDLE);
    assign done      = done_q;

endmodule
